// File: rtl/game_timing_pkg.sv
// Shared timing types and defaults for the whack-a-mole pace logic.
// Pure declarations; no clocked logic and no flow control of its own.
package game_timing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_DIV    = 32'd9999999;
  localparam int unsigned DEF_STEP_DIV    = 32'd1000000;
  localparam int unsigned DEF_MIN_DIV     = 32'd2000000;
  localparam int unsigned DEF_ROUND_TICKS = 32'd30;

  // max(base - red, floor_div); a reduction at or past base clamps to the floor.
  function automatic logic [63:0] clamp_div(input logic [63:0] base,
                                            input logic [63:0] red,
                                            input logic [63:0] floor_div);
    logic [63:0] d;
    d = (red >= base) ? 64'd0 : (base - red);
    return (d < floor_div) ? floor_div : d;
  endfunction

endpackage

// File: rtl/period_counter.sv
// Free-running period counter: hit when count equals the latched terminal, then wraps to 0.
// hit is combinational from registered state; en low freezes the count (no other backpressure).
module period_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] term_q;

  assign hit = en && (cnt_q == term_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else begin
      if (load) begin
        term_q <= term;
      end
      if (clr || hit) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/difficulty_tick_scheduler.sv
// Game-pace tick generator: one-cycle tick every div+1 cycles, round of ROUND_TICKS, all outputs registered.
// pause level freezes the round (1-cycle latency); optional slow_clk square wave under DIFF_SCHED_SQUARE_OUT_EN.
module difficulty_tick_scheduler
  import game_timing_pkg::*;
#(
  parameter int unsigned BASE_DIV    = DEF_BASE_DIV,
  parameter int unsigned STEP_DIV    = DEF_STEP_DIV,
  parameter int unsigned MIN_DIV     = DEF_MIN_DIV,
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned ROUND_TICKS = DEF_ROUND_TICKS,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               level_up,
  output logic               tick,
  output logic               round_done,
  output logic               busy,
  output logic [LEVEL_W-1:0] level,
`ifdef DIFF_SCHED_SQUARE_OUT_EN
  output logic               slow_clk,
`endif
  output logic [7:0]         ticks_left
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;
  localparam logic [7:0]         ROUND_LEFT = 8'(ROUND_TICKS);
  localparam logic [CNT_W-1:0]   BASE_TERM  = CNT_W'(BASE_DIV);

  state_e             state_q, state_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [7:0]         left_q, left_d;
  logic               cnt_clr, cnt_en, cnt_load, hit;
  logic [CNT_W-1:0]   next_div, term_d;

  // 64-bit arithmetic covers CNT_W+LEVEL_W so level*STEP_DIV cannot wrap.
  assign next_div = CNT_W'(clamp_div(64'(BASE_DIV), 64'(level_q) * 64'(STEP_DIV), 64'(MIN_DIV)));

  period_counter #(.CNT_W(CNT_W)) u_period (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .load  (cnt_load),
    .term  (term_d),
    .hit   (hit)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    left_d   = left_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    term_d   = next_div;
    case (state_q)
      IDLE, DONE: begin
        // busy_q is still high in the round_done cycle, so a start there is ignored.
        if (start && !busy_q) begin
          state_d  = RUN;
          cnt_clr  = 1'b1;
          cnt_load = 1'b1;
          term_d   = BASE_TERM;
          level_d  = '0;
          left_d   = ROUND_LEFT;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (hit) begin
          tick_d   = 1'b1;
          cnt_load = 1'b1;
          left_d   = left_q - 8'd1;
          done_d   = (left_q == 8'd1);
        end
        if (done_d) begin
          state_d = DONE;
        end else if (pause) begin
          state_d = PAUSED;
        end
        if (level_up && (level_q != LEVEL_MAX)) begin
          level_d = level_q + 1'b1;
        end
      end
      PAUSED: begin
        if (!pause) begin
          state_d = RUN;
        end
        if (level_up && (level_q != LEVEL_MAX)) begin
          level_d = level_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == PAUSED) || done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      level_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      level_q <= level_d;
      left_q  <= left_d;
    end
  end

  assign tick       = tick_q;
  assign round_done = done_q;
  assign busy       = busy_q;
  assign level      = level_q;
  assign ticks_left = left_q;

`ifdef DIFF_SCHED_SQUARE_OUT_EN
  logic slow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slow_q <= 1'b0;
    end else if (tick_d) begin
      slow_q <= ~slow_q;
    end
  end

  assign slow_clk = slow_q;
`endif

endmodule

// File: tb/tb_difficulty_tick_scheduler.sv
// Directed bench for difficulty_tick_scheduler with BASE_DIV=9, STEP_DIV=2, MIN_DIV=3, ROUND_TICKS=4.
// Checks slow_clk too when DIFF_SCHED_SQUARE_OUT_EN is defined.
module tb_difficulty_tick_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic       level_up;
  logic       tick;
  logic       round_done;
  logic       busy;
  logic [2:0] level;
  logic [7:0] ticks_left;
`ifdef DIFF_SCHED_SQUARE_OUT_EN
  logic       slow_clk;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  difficulty_tick_scheduler #(
    .BASE_DIV    (9),
    .STEP_DIV    (2),
    .MIN_DIV     (3),
    .LEVEL_W     (3),
    .ROUND_TICKS (4),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .level_up   (level_up),
    .tick       (tick),
    .round_done (round_done),
    .busy       (busy),
    .level      (level),
`ifdef DIFF_SCHED_SQUARE_OUT_EN
    .slow_clk   (slow_clk),
`endif
    .ticks_left (ticks_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int n_lu;
    int exp_level;
    int exp_period;
  } row_t;

  row_t rows[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((tick !== 1'b1) && (n < maxc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic start_round();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    int tcount;
    int lvl_before;
    logic sc0;

    rows[0] = '{0, 0, 10};
    rows[1] = '{1, 1, 8};
    rows[2] = '{2, 2, 6};
    rows[3] = '{3, 3, 4};
    rows[4] = '{4, 4, 4};
    rows[5] = '{7, 7, 4};
    rows[6] = '{9, 7, 4};

    reset    = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    level_up = 1'b0;
    sc0      = 1'b0;
    step();
    chk("rst_tick", int'(tick), 0);
    chk("rst_done", int'(round_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_left", int'(ticks_left), 0);
`ifdef DIFF_SCHED_SQUARE_OUT_EN
    chk("rst_slow", int'(slow_clk), 0);
`endif

    // Table: level_ups before the first tick set the divisor for period 2 onward.
    for (int r = 0; r < 7; r++) begin
      do_reset();
      chk("idle_busy", int'(busy), 0);
      start_round();
      chk("start_busy", int'(busy), 1);
      chk("start_left", int'(ticks_left), 4);
      chk("start_level", int'(level), 0);
      k = 0;
      do begin
        level_up = (k < rows[r].n_lu);
        step();
        k++;
      end while ((tick !== 1'b1) && (k < 30));
      level_up = 1'b0;
      chk("first_tick", k, 10);
      chk("row_level", int'(level), rows[r].exp_level);
      chk("left_after1", int'(ticks_left), 3);
      wait_tick(30, n);
      chk("period2", n, rows[r].exp_period);
      chk("done_early", int'(round_done), 0);
      wait_tick(30, n);
      chk("period3", n, rows[r].exp_period);
      wait_tick(30, n);
      chk("period4", n, rows[r].exp_period);
      chk("last_done", int'(round_done), 1);
      chk("last_left", int'(ticks_left), 0);
      chk("last_busy", int'(busy), 1);
      step();
      chk("post_busy", int'(busy), 0);
      chk("post_done", int'(round_done), 0);
      chk("post_tick", int'(tick), 0);
    end

    // level_up 3 cycles after the first tick only affects the third period.
    do_reset();
    start_round();
    wait_tick(30, n);
    chk("lb_first", n, 10);
    step();
    step();
    level_up = 1'b1;
    step();
    level_up = 1'b0;
    chk("lb_level", int'(level), 1);
    wait_tick(30, n);
    chk("lb_period2", n + 3, 10);
    wait_tick(30, n);
    chk("lb_period3", n, 8);

    // Pause for 20 cycles mid-period; level_up while paused is honoured but deferred.
    do_reset();
    start_round();
    level_up = 1'b1;
    step();
    level_up = 1'b0;
    wait_tick(30, n);
    chk("pz_first", n + 1, 10);
    step();
    step();
    step();
    pause  = 1'b1;
    tcount = 0;
    for (int i = 0; i < 20; i++) begin
      level_up = (i == 10);
      step();
      if (tick === 1'b1) tcount++;
    end
    pause    = 1'b0;
    level_up = 1'b0;
    chk("pz_no_tick", tcount, 0);
    chk("pz_left", int'(ticks_left), 3);
    chk("pz_busy", int'(busy), 1);
    chk("pz_level", int'(level), 2);
    wait_tick(60, n);
    chk("pz_period", 3 + 20 + n, 28);
    chk("pz_left2", int'(ticks_left), 2);

    // Reset mid-round clears everything at once; start while busy is ignored.
    do_reset();
    start_round();
    level_up = 1'b1;
    step();
    level_up = 1'b0;
    repeat (4) step();
    chk("mr_level", int'(level), 1);
    reset = 1'b1;
    #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_level0", int'(level), 0);
    chk("mr_left", int'(ticks_left), 0);
    chk("mr_tick", int'(tick), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    start_round();
    wait_tick(30, n);
    chk("mr_first", n, 10);
    step();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ig_left", int'(ticks_left), 3);
    wait_tick(30, n);
    chk("ig_period", n + 4, 10);

    // start together with pause in IDLE: RUN first, pause taken on the next edge.
    do_reset();
    start = 1'b1;
    pause = 1'b1;
    step();
    start = 1'b0;
    chk("sp_busy", int'(busy), 1);
    repeat (4) step();
    pause = 1'b0;
    wait_tick(40, n);
    chk("sp_first", n + 4, 14);

    // pause sampled on the tick edge: the tick completes, then counting stops.
    do_reset();
    start_round();
    wait_tick(30, n);
    chk("co_first", n, 10);
`ifdef DIFF_SCHED_SQUARE_OUT_EN
    chk("co_slow1", int'(slow_clk), 1);
`endif
    repeat (9) step();
    pause = 1'b1;
    step();
    chk("co_tick", int'(tick), 1);
    chk("co_left", int'(ticks_left), 2);
`ifdef DIFF_SCHED_SQUARE_OUT_EN
    sc0 = slow_clk;
    chk("co_slow2", int'(sc0), 0);
`endif
    tcount     = 0;
    lvl_before = int'(level);
    for (int i = 0; i < 14; i++) begin
      step();
      if (tick === 1'b1) tcount++;
    end
    pause = 1'b0;
    chk("co_no_tick", tcount, 0);
    chk("co_left_hold", int'(ticks_left), 2);
    chk("co_level_hold", int'(level), lvl_before);
`ifdef DIFF_SCHED_SQUARE_OUT_EN
    chk("co_slow_hold", int'(slow_clk), int'(sc0));
`endif
    wait_tick(40, n);
    chk("co_period", 14 + n, 25);
`ifdef DIFF_SCHED_SQUARE_OUT_EN
    chk("co_slow3", int'(slow_clk), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
